// File: rtl/pwm_hue_pkg.sv
// Shared types and the hue-to-colour mapping for the PWM colour wheel.
package pwm_hue_pkg;

  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeHold  = 2'b01,
    ModeCycle = 2'b10,
    ModeStep  = 2'b11
  } mode_t;

  localparam int unsigned NUM_SEG = 6;
  localparam int unsigned MaxRes  = 12;

  typedef struct packed {
    logic [MaxRes-1:0] red;
    logic [MaxRes-1:0] green;
    logic [MaxRes-1:0] blue;
  } rgb_duty_t;

  // Callers zero-extend ramp/max_val from their resolution R and truncate the result back to R.
  function automatic rgb_duty_t hue_to_rgb(input logic [2:0]        seg,
                                           input logic [MaxRes-1:0] ramp,
                                           input logic [MaxRes-1:0] max_val);
    rgb_duty_t d;
    d = '0;
    case (seg)
      3'd0: begin d.red = max_val;        d.green = ramp;           end
      3'd1: begin d.red = max_val - ramp; d.green = max_val;        end
      3'd2: begin d.green = max_val;      d.blue = ramp;            end
      3'd3: begin d.green = max_val - ramp; d.blue = max_val;       end
      3'd4: begin d.red = ramp;           d.blue = max_val;         end
      3'd5: begin d.red = max_val;        d.blue = max_val - ramp;  end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register reloaded at period boundaries, compare, registered pin.
module pwm_channel #(
  parameter int unsigned R = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         reload_i,
  input  logic         off_i,
  input  logic [R-1:0] duty_i,
  input  logic [R-1:0] cnt_next_i,
  output logic         pwm_o
);

  logic [R-1:0] shadow_q, shadow_d;
  logic         out_q, out_d;

  // Compare against the incoming shadow so the first slot of a new period uses the new duty.
  always_comb begin
    shadow_d = reload_i ? duty_i : shadow_q;
    out_d    = !off_i && (cnt_next_i < shadow_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      out_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  assign pwm_o = out_q;

endmodule

// File: rtl/pwm_hue_wheel.sv
// RGB colour-wheel generator: hue position, colour map and three shared-prescaler PWM channels.
// Optional global dimming via the PWM_HUE_DIM_EN macro (adds the brightness port).
module pwm_hue_wheel
  import pwm_hue_pkg::*;
#(
  parameter int unsigned R      = 8,
  parameter int unsigned DVSR_W = 13,
  parameter int unsigned STEP_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [STEP_W-1:0] step_period,
  input  logic [1:0]        mode,
  input  logic              step_req,
  input  logic              hue_load,
  input  logic [2:0]        hue_seg_in,
  input  logic [R-1:0]      hue_ramp_in,
`ifdef PWM_HUE_DIM_EN
  input  logic [R-1:0]      brightness,
`endif
  output logic [2:0]        rgb,
  output logic [2:0]        hue_seg,
  output logic [R-1:0]      hue_ramp,
  output logic              period_start
);

  localparam logic [R-1:0] Max     = '1;
  localparam logic [2:0]   LastSeg = 3'(NUM_SEG - 1);

  mode_t mode_e;
  assign mode_e = mode_t'(mode);

  logic [DVSR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [R-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]        seg_q, seg_d;
  logic [R-1:0]      ramp_q, ramp_d;
  logic              tick, reload, cycle_step, step;

  always_comb begin
    tick      = (pre_cnt_q == dvsr);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + {{(R-1){1'b0}}, tick};
    reload    = tick && (pwm_cnt_q == Max);
  end

  // The step counter only runs in CYCLE mode so re-entering it always starts a full interval.
  always_comb begin
    step_cnt_d = '0;
    cycle_step = 1'b0;
    if (mode_e == ModeCycle) begin
      if (step_cnt_q == step_period) begin
        cycle_step = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
    step = ((mode_e == ModeCycle) && cycle_step) || ((mode_e == ModeStep) && step_req);
  end

  always_comb begin
    seg_d  = seg_q;
    ramp_d = ramp_q;
    if (hue_load) begin
      seg_d  = (hue_seg_in > LastSeg) ? 3'd0 : hue_seg_in;
      ramp_d = hue_ramp_in;
    end else if (step) begin
      if (ramp_q == Max) begin
        ramp_d = '0;
        seg_d  = (seg_q == LastSeg) ? 3'd0 : seg_q + 3'd1;
      end else begin
        ramp_d = ramp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      seg_q      <= '0;
      ramp_q     <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      seg_q      <= seg_d;
      ramp_q     <= ramp_d;
    end
  end

  rgb_duty_t    map_full;
  logic [R-1:0] map_r, map_g, map_b;
  logic [R-1:0] duty_r, duty_g, duty_b;
  logic         unused_map;

  assign map_full = hue_to_rgb(seg_q, MaxRes'(ramp_q), MaxRes'(Max));
  assign map_r    = map_full.red[R-1:0];
  assign map_g    = map_full.green[R-1:0];
  assign map_b    = map_full.blue[R-1:0];
  // Bits above R are always zero; fold them in so nothing is left dangling.
  assign unused_map = ^map_full;

`ifdef PWM_HUE_DIM_EN
  logic [2*R-1:0] prod_r, prod_g, prod_b;
  assign prod_r = {{R{1'b0}}, map_r} * {{R{1'b0}}, brightness};
  assign prod_g = {{R{1'b0}}, map_g} * {{R{1'b0}}, brightness};
  assign prod_b = {{R{1'b0}}, map_b} * {{R{1'b0}}, brightness};
  assign duty_r = prod_r[2*R-1:R];
  assign duty_g = prod_g[2*R-1:R];
  assign duty_b = prod_b[2*R-1:R];
`else
  assign duty_r = map_r;
  assign duty_g = map_g;
  assign duty_b = map_b;
`endif

  logic off;
  assign off = (mode_e == ModeOff);

  pwm_channel #(.R(R)) u_red (
    .clk        (clk),
    .reset_n    (reset_n),
    .reload_i   (reload),
    .off_i      (off),
    .duty_i     (duty_r),
    .cnt_next_i (pwm_cnt_d),
    .pwm_o      (rgb[0])
  );

  pwm_channel #(.R(R)) u_blue (
    .clk        (clk),
    .reset_n    (reset_n),
    .reload_i   (reload),
    .off_i      (off),
    .duty_i     (duty_b),
    .cnt_next_i (pwm_cnt_d),
    .pwm_o      (rgb[1])
  );

  pwm_channel #(.R(R)) u_green (
    .clk        (clk),
    .reset_n    (reset_n),
    .reload_i   (reload),
    .off_i      (off),
    .duty_i     (duty_g),
    .cnt_next_i (pwm_cnt_d),
    .pwm_o      (rgb[2])
  );

  assign hue_seg      = seg_q;
  assign hue_ramp     = ramp_q;
  assign period_start = reload;

endmodule

// File: tb/tb_pwm_hue_wheel.sv
// Directed self-checking bench for pwm_hue_wheel at R=4, dvsr=0.
module tb_pwm_hue_wheel;

  localparam int unsigned R = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [12:0]   dvsr;
  logic [31:0]   step_period;
  logic [1:0]    mode;
  logic          step_req;
  logic          hue_load;
  logic [2:0]    hue_seg_in;
  logic [R-1:0]  hue_ramp_in;
  logic [R-1:0]  brightness;
  logic [2:0]    rgb;
  logic [2:0]    hue_seg;
  logic [R-1:0]  hue_ramp;
  logic          period_start;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pwm_hue_wheel #(.R(R), .DVSR_W(13), .STEP_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dvsr         (dvsr),
    .step_period  (step_period),
    .mode         (mode),
    .step_req     (step_req),
    .hue_load     (hue_load),
    .hue_seg_in   (hue_seg_in),
    .hue_ramp_in  (hue_ramp_in),
`ifdef PWM_HUE_DIM_EN
    .brightness   (brightness),
`endif
    .rgb          (rgb),
    .hue_seg      (hue_seg),
    .hue_ramp     (hue_ramp),
    .period_start (period_start)
  );

  // High slots per 16-slot period for a mapped value v (brightness fixed at 15 when dimming).
  function automatic int exp_duty(input int v);
`ifdef PWM_HUE_DIM_EN
    return (v * 15) >> 4;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  initial begin
    int nr, ng, nb, bad, found, waited;
    logic [15:0] ps_bits;
    logic [2:0]  mseg;
    logic [3:0]  mramp;

    reset_n = 1'b0; dvsr = '0; step_period = 32'd1000; mode = 2'b10;
    step_req = 1'b0; hue_load = 1'b0; hue_seg_in = '0; hue_ramp_in = '0;
    brightness = 4'd15;

    // Reset values and first boundary
    repeat (3) @(negedge clk);
    chk("reset_rgb", 32'(rgb), 0);
    chk("reset_seg", 32'(hue_seg), 0);
    chk("reset_ramp", 32'(hue_ramp), 0);
    chk("reset_pstart", 32'(period_start), 0);
    reset_n = 1'b1;
    bad = 0; ps_bits = '0;
    for (int i = 0; i < 16; i++) begin
      if (rgb !== 3'b000) bad++;
      ps_bits[i] = period_start;
      @(negedge clk);
    end
    chk("first_period_dark", 32'(bad), 0);
    chk("first_pstart_at_15", 32'(ps_bits), 32'h8000);
    nr = 0; ng = 0; nb = 0;
    for (int i = 0; i < 16; i++) begin
      nr += int'(rgb[0]); nb += int'(rgb[1]); ng += int'(rgb[2]);
      @(negedge clk);
    end
    chk("first_red", 32'(nr), 32'(exp_duty(15)));
    chk("first_green", 32'(ng), 0);
    chk("first_blue", 32'(nb), 0);

    // Full wheel, one step per cycle
    reset_n = 1'b0; step_period = '0; mode = 2'b10;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mseg = '0; mramp = '0; bad = 0;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (mramp == 4'd15) begin
        mramp = '0;
        mseg  = (mseg == 3'd5) ? 3'd0 : mseg + 3'd1;
      end else begin
        mramp = mramp + 4'd1;
      end
      if (hue_seg !== mseg || hue_ramp !== mramp) bad++;
      if (k == 15) chk("wheel_0_15", {hue_seg, 4'(hue_ramp)}, {3'd0, 4'd15});
      if (k == 16) chk("wheel_1_0", {hue_seg, 4'(hue_ramp)}, {3'd1, 4'd0});
      if (k == 95) chk("wheel_5_15", {hue_seg, 4'(hue_ramp)}, {3'd5, 4'd15});
      if (k == 96) chk("wheel_wrap", {hue_seg, 4'(hue_ramp)}, {3'd0, 4'd0});
    end
    chk("wheel_walk", 32'(bad), 0);

    // Asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chk("async_ramp", 32'(hue_ramp), 0);
    chk("async_rgb", 32'(rgb), 0);
    chk("async_pstart", 32'(period_start), 0);

    // Load priority in STEP mode
    mode = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    hue_load = 1'b1; hue_seg_in = 3'd3; hue_ramp_in = 4'd7; step_req = 1'b1;
    @(negedge clk);
    hue_load = 1'b0; step_req = 1'b0;
    chk("load_prio", {hue_seg, 4'(hue_ramp)}, {3'd3, 4'd7});
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("step_after_load", {hue_seg, 4'(hue_ramp)}, {3'd3, 4'd8});
    repeat (5) @(negedge clk);
    chk("step_no_req", {hue_seg, 4'(hue_ramp)}, {3'd3, 4'd8});
    hue_load = 1'b1; hue_seg_in = 3'd7; hue_ramp_in = 4'd2;
    @(negedge clk);
    hue_load = 1'b0;
    chk("load_bad_seg", {hue_seg, 4'(hue_ramp)}, {3'd0, 4'd2});
    hue_load = 1'b1; hue_seg_in = 3'd5; hue_ramp_in = 4'd15;
    @(negedge clk);
    hue_load = 1'b0; step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("step_wrap", {hue_seg, 4'(hue_ramp)}, {3'd0, 4'd0});
    hue_load = 1'b1; hue_seg_in = 3'd1; hue_ramp_in = 4'd4;
    @(negedge clk);
    hue_load = 1'b0; mode = 2'b01; step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("hold_ignores_req", {hue_seg, 4'(hue_ramp)}, {3'd1, 4'd4});

    // Glitch-free duty update
    hue_load = 1'b1; hue_seg_in = 3'd0; hue_ramp_in = 4'd0;
    @(negedge clk);
    hue_load = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (period_start === 1'b1) found = 1;
      else @(negedge clk);
    end
    chk("pstart_found", 32'(found), 1);
    nr = 0; ng = 0; nb = 0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      nr += int'(rgb[0]); nb += int'(rgb[1]); ng += int'(rgb[2]);
      if (j == 8) begin
        hue_load = 1'b1; hue_seg_in = 3'd2; hue_ramp_in = 4'd15;
      end
      if (j == 9) hue_load = 1'b0;
    end
    chk("pre_update_red", 32'(nr), 32'(exp_duty(15)));
    chk("pre_update_gb", 32'(ng + nb), 0);
    chk("update_pstart", 32'(period_start), 1);
    nr = 0; ng = 0; nb = 0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      nr += int'(rgb[0]); nb += int'(rgb[1]); ng += int'(rgb[2]);
    end
    chk("post_update_red", 32'(nr), 0);
    chk("post_update_green", 32'(ng), 32'(exp_duty(15)));
    chk("post_update_blue", 32'(nb), 32'(exp_duty(15)));

    // OFF mid-period, then resume
    mode = 2'b10; step_period = 32'd1000;
    repeat (3) @(negedge clk);
    chk("pre_off_rgb", 32'(rgb), 32'b110);
    mode = 2'b00;
    @(negedge clk);
    chk("off_next_cycle", 32'(rgb), 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rgb !== 3'b000) bad++;
    end
    chk("off_stays_dark", 32'(bad), 0);
    chk("off_hue_frozen", {hue_seg, 4'(hue_ramp)}, {3'd2, 4'd15});
    mode = 2'b10; step_period = 32'd2;
    waited = 0;
    for (int i = 0; i < 10 && hue_ramp === 4'd15; i++) begin
      @(negedge clk);
      waited++;
    end
    chk("resume_hue", {hue_seg, 4'(hue_ramp)}, {3'd3, 4'd0});
    chk("resume_latency", 32'(waited), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
